// File: rtl/uac2_pkg.sv
// Shared constants and helpers for the UAC2 stereo frame path: frame geometry,
// the word-phase encoding and the packing of one stereo frame into a FIFO word.
package uac2_pkg;

    localparam int WORD_W          = 16;
    localparam int WORDS_PER_FRAME = 4;
    localparam int SUBSLOT_W       = 32;
    localparam int FIFO_WORD_W     = 64;

    // Position of the next incoming 16-bit word within a stereo frame.
    typedef enum logic [1:0] {
        PH_L_LO = 2'd0,
        PH_L_HI = 2'd1,
        PH_R_LO = 2'd2,
        PH_R_HI = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t ph);
        return phase_t'(ph + 2'd1);
    endfunction

    // The left sample sits in the upper half of a FIFO word and the right sample in the lower half.
    function automatic logic [FIFO_WORD_W-1:0] pack_frame(input logic [SUBSLOT_W-1:0] left,
                                                          input logic [SUBSLOT_W-1:0] right);
        return {left, right};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and a level counter. It has no
// overflow or underflow protection: the caller issues wr_en/rd_en only when they are legal.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             ifclk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage is deliberately left out of reset; the pointers and level define
    // which entries are meaningful, so resetting the array would only add reset fan-out.
    always_ff @(posedge ifclk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments, so a read and a write
    // of the same entry on one edge return the old contents (needed when full).
    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/usb_frame_unpacker.sv
// Reassembles the FX2 EP2 16-bit audio word stream into stereo 32-bit UAC2 frames,
// buffers them for the DAC stage and keeps sticky overflow/underflow flags.
module usb_frame_unpacker
    import uac2_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                 ifclk,
    input  logic                 rst_n,
    input  logic [WORD_W-1:0]    word_in,
    input  logic                 word_valid,
    input  logic                 resync,
    input  logic                 rd_en,
    output logic [SUBSLOT_W-1:0] rd_left,
    output logic [SUBSLOT_W-1:0] rd_right,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 full,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_flags
);

    phase_t             phase;
    logic [WORD_W-1:0]  l_lo;
    logic [WORD_W-1:0]  l_hi;
    logic [WORD_W-1:0]  r_lo;

    logic                   rd_accept;
    logic                   frame_done;
    logic                   wr_accept;
    logic                   drop_frame;
    logic [FIFO_WORD_W-1:0] wr_data;
    logic [FIFO_WORD_W-1:0] rd_data;

    // A word arriving with resync is always phase 0, so it can never complete a frame.
    assign frame_done = word_valid && !resync && (phase == PH_R_HI);
    assign rd_accept  = rd_en && !empty;
    assign wr_accept  = frame_done && (!full || rd_accept);
    assign drop_frame = frame_done && full && !rd_accept;
    assign wr_data    = pack_frame({l_hi, l_lo}, {word_in, r_lo});

    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_L_LO;
            l_lo  <= '0;
            l_hi  <= '0;
            r_lo  <= '0;
        end else if (resync) begin
            l_hi  <= '0;
            r_lo  <= '0;
            l_lo  <= word_valid ? word_in : '0;
            phase <= word_valid ? PH_L_HI : PH_L_LO;
        end else if (word_valid) begin
            case (phase)
                PH_L_LO: l_lo <= word_in;
                PH_L_HI: l_hi <= word_in;
                PH_R_LO: r_lo <= word_in;
                default: ;
            endcase
            phase <= next_phase(phase);
        end
    end

    // A new error event takes precedence over a coincident clear.
    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop_frame)       overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;

            if (rd_en && empty)   underflow <= 1'b1;
            else if (clear_flags) underflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ifclk    (ifclk),
        .rst_n    (rst_n),
        .wr_en    (wr_accept),
        .wr_data  (wr_data),
        .rd_en    (rd_accept),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    assign rd_left  = rd_data[FIFO_WORD_W-1:SUBSLOT_W];
    assign rd_right = rd_data[SUBSLOT_W-1:0];

endmodule

// File: tb/tb_usb_frame_unpacker.sv
// Scoreboard bench for usb_frame_unpacker: a queue-based reference model predicts
// popped frames, FIFO level and flags; a separate monitor checks every rd_valid.
module tb_usb_frame_unpacker;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          ifclk;
    logic          rst_n;
    logic [15:0]   word_in;
    logic          word_valid;
    logic          resync;
    logic          rd_en;
    logic [31:0]   rd_left;
    logic [31:0]   rd_right;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;
    logic          clear_flags;

    usb_frame_unpacker #(.DEPTH(DEPTH)) dut (
        .ifclk       (ifclk),
        .rst_n       (rst_n),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .resync      (resync),
        .rd_en       (rd_en),
        .rd_left     (rd_left),
        .rd_right    (rd_right),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    initial ifclk = 1'b0;
    always #5 ifclk = ~ifclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: words of the frame in progress, stored frames, frames expected on the read port.
    logic [15:0] m_words[$];
    logic [63:0] m_fifo[$];
    logic [63:0] sb[$];
    bit          m_over;
    bit          m_under;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_fifo.delete();
        sb.delete();
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    // Applies the rules to the inputs present at one clock edge.
    task automatic model_edge();
        int          n;
        bit          rd_ok;
        bit          ov_ev;
        logic [63:0] fr;
        n     = m_fifo.size();
        rd_ok = rd_en && (n > 0);
        ov_ev = 1'b0;
        if (rd_ok) sb.push_back(m_fifo.pop_front());
        if (resync) m_words.delete();
        if (word_valid) m_words.push_back(word_in);
        if (m_words.size() == 4) begin
            fr = {m_words[1], m_words[0], m_words[3], m_words[2]};
            m_words.delete();
            if (n < DEPTH || rd_ok) m_fifo.push_back(fr);
            else                    ov_ev = 1'b1;
        end
        if (ov_ev)            m_over = 1'b1;
        else if (clear_flags) m_over = 1'b0;
        if (rd_en && n == 0)  m_under = 1'b1;
        else if (clear_flags) m_under = 1'b0;
    endtask

    task automatic check_state();
        int n;
        n = m_fifo.size();
        check("level",     64'(level),     64'(n));
        check("empty",     64'(empty),     64'(n == 0));
        check("full",      64'(full),      64'(n == DEPTH));
        check("overflow",  64'(overflow),  64'(m_over));
        check("underflow", 64'(underflow), 64'(m_under));
    endtask

    // Called at a falling edge: drives inputs, lets one rising edge happen, checks at the next falling edge.
    task automatic step(input bit v, input logic [15:0] w, input bit rs, input bit rd, input bit clr);
        word_valid  = v;
        word_in     = w;
        resync      = rs;
        rd_en       = rd;
        clear_flags = clr;
        @(posedge ifclk);
        model_edge();
        @(negedge ifclk);
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input bit rd_last, input int max_gap);
        logic [15:0] w[4];
        w[0] = l[15:0];
        w[1] = l[31:16];
        w[2] = r[15:0];
        w[3] = r[31:16];
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            step(1'b1, w[i], 1'b0, (i == 3) && rd_last, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " level"},     64'(level),     64'd0);
        check({tag, " empty"},     64'(empty),     64'd1);
        check({tag, " full"},      64'(full),      64'd0);
        check({tag, " rd_valid"},  64'(rd_valid),  64'd0);
        check({tag, " rd_left"},   64'(rd_left),   64'd0);
        check({tag, " rd_right"},  64'(rd_right),  64'd0);
        check({tag, " overflow"},  64'(overflow),  64'd0);
        check({tag, " underflow"}, 64'(underflow), 64'd0);
    endtask

    // Monitor: every queued expectation must appear as an rd_valid pulse on the next falling edge, and vice versa.
    always @(negedge ifclk) begin
        if (rst_n && (rd_valid || sb.size() > 0)) begin
            logic [63:0] e;
            check("rd_valid", 64'(rd_valid), 64'(sb.size() > 0));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (rd_valid) begin
                    check("rd_left",  64'(rd_left),  64'(e[63:32]));
                    check("rd_right", 64'(rd_right), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        int rd_pct;
        rst_n       = 1'b0;
        word_in     = '0;
        word_valid  = 1'b0;
        resync      = 1'b0;
        rd_en       = 1'b0;
        clear_flags = 1'b0;
        model_reset();
        repeat (2) @(negedge ifclk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge ifclk);

        // Basic frame assembly and pop.
        step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
        idle(2);

        // Resync after a partial frame, then resync coincident with the first word.
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0,    1'b1, 1'b0, 1'b0);
        send_frame(32'h0002_0001, 32'h0004_0003, 1'b0, 3);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        idle($urandom_range(0, 3));
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Overfill: DEPTH+1 frames, then drain plus one extra read.
        for (int i = 0; i <= DEPTH; i++) send_frame($urandom, $urandom, 1'b0, 0);
        for (int i = 0; i <= DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Frame completing on a full FIFO together with a read.
        for (int i = 0; i < DEPTH; i++) send_frame($urandom, $urandom, 1'b0, 0);
        send_frame(32'hCAFE_0001, 32'hBEEF_0002, 1'b1, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Underflow and flag clear priority.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        // Write into an empty FIFO with a coincident read counts as underflow.
        step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h8888, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Reset in the middle of a frame with a stored frame present.
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        word_valid = 1'b0;
        rst_n      = 1'b0;
        #2;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge ifclk);
        rst_n = 1'b1;
        idle(1);
        send_frame(32'h0BAD_F00D, 32'h600D_CAFE, 1'b0, 1);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Randomised traffic with varying read pressure.
        rd_pct = 40;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) rd_pct = $urandom_range(5, 60);
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 63) == 0,
                 $urandom_range(0, 99) < rd_pct, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i <= DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_frame_unpacker.md
Name: usb_frame_unpacker

Overview:
- Consumes the 16-bit word stream from the FX2 slave-FIFO interface (EP2 OUT audio data, one word per valid cycle) and reassembles stereo UAC2 frames: 32-bit subslots, little-endian, L then R, i.e. 4 words per frame.
- Buffers complete frames in a small synchronous FIFO for the downstream I2S/DAC stage.
- Reports fill level and error flags for the rate-feedback logic.
- Single clock domain (ifclk).

Parameters:
- DEPTH, 16, FIFO capacity in stereo frames; power of 2, minimum 4.
- LW, $clog2(DEPTH)+1, width of the level output (derived; do not override).

Ports:
- ifclk  in  1  interface clock
- rst_n  in  1  reset
- word_in  in  16  audio word from FX2 interface (its data_out)
- word_valid  in  1  word_in valid this cycle (its data_out_valid)
- resync  in  1  one-cycle pulse: discard partial frame and restart at word 0
- rd_en  in  1  downstream request for one frame
- rd_left  out  32  left sample of the popped frame
- rd_right  out  32  right sample of the popped frame
- rd_valid  out  1  rd_left/rd_right valid this cycle
- empty  out  1  FIFO holds 0 frames
- full  out  1  FIFO holds DEPTH frames
- level  out  LW  frames currently stored, 0..DEPTH
- overflow  out  1  sticky: a complete frame was dropped because the FIFO was full
- underflow  out  1  sticky: rd_en asserted while empty
- clear_flags  in  1  one-cycle pulse: clears overflow and underflow

Interface: reset is rst_n, asynchronous, active-low; clock is ifclk.

Behaviour:
- Reset: phase=0, assembly registers=0, FIFO pointers=0, level=0, empty=1, full=0, rd_valid=0, rd_left=rd_right=0, overflow=0, underflow=0.
- Assembly: 2-bit phase counter advances on each word_valid.
  - phase0 = L[15:0], phase1 = L[31:16], phase2 = R[15:0], phase3 = R[31:16].
  - Phases 0–2 capture into holding registers.
  - On the phase-3 word, the frame {L, R=word_in & R_lo} is written to the FIFO on the same edge; phase wraps to 0.
- Word gaps: non-valid cycles between words are allowed and do not change phase.
- resync: sets phase=0 and discards held words. If word_valid coincides with resync, that word is taken as phase 0 and phase becomes 1.
- Write latency: level/empty/full reflect a committed frame on the cycle after the phase-3 word edge.
- Overflow: a frame completed while full with no concurrent accepted read is dropped whole; overflow is set; phase still wraps to 0. A frame completed while full with a concurrent accepted read is stored, and level stays DEPTH.
- Read: rd_en with !empty pops the head frame. rd_left/rd_right are registered and valid with rd_valid=1 exactly one cycle later. rd_valid is a 1-cycle pulse; the data outputs hold their last value otherwise.
- Underflow: rd_en with empty is ignored, rd_valid stays 0, underflow is set.
- Simultaneous write and read (non-full, non-empty): both occur and level is unchanged. Write into an empty FIFO plus rd_en in the same cycle: the read is treated as underflow (empty is registered).
- Flag priority: clear_flags coincident with a new error event leaves the flag set (set wins).
- Pointers: log2(DEPTH) bits, natural wrap. level is a counter updated by +1/−1/0. full = (level==DEPTH), empty = (level==0).
- Reset mid-frame: all state, including partial frames and FIFO contents, is lost; no output is produced until a new 4-word frame arrives.

Decomposition:
- Shared package uac2_pkg:
  - WORDS_PER_FRAME=4, SUBSLOT_W=32, FIFO_WORD_W=64
  - phase encoding constants PH_L_LO, PH_L_HI, PH_R_LO, PH_R_HI
- Sub-module sync_fifo:
  - parameters WIDTH=64, DEPTH
  - ports wr_en/wr_data/rd_en/rd_data/rd_valid/level/empty/full
  - registered read, no internal flags
- Assembly, error flags and resync logic stay in usb_frame_unpacker.

Test Plan:
1. Reset, then 4 consecutive words 0x1111, 0x2222, 0x3333, 0x4444 → level=1 one cycle after the 4th. rd_en pulse → next cycle rd_valid=1, rd_left=0x22221111, rd_right=0x44443333, level=0, empty=1.
2. Words 0xAAAA, 0xBBBB, then resync, then 0x0001, 0x0002, 0x0003, 0x0004 with idle gaps of 0–3 cycles → exactly one frame: L=0x00020001, R=0x00040003. Repeat with resync coincident with 0x0001 → same result.
3. Write DEPTH+1 frames with no reads → full=1, level=DEPTH, overflow=1. Popping all frames returns the first DEPTH frames in order; the last one is absent.
4. Full FIFO with a frame completing on the same cycle as rd_en → level stays DEPTH, overflow stays 0, pop order intact.
5. rd_en while empty → rd_valid=0, underflow=1. clear_flags → underflow=0 next cycle. clear_flags coincident with another empty rd_en → underflow stays 1.
6. Assert rst_n low after 2 words of a frame → all outputs at reset values. After release, 4 words produce one correct frame with no stale data.
